mem_port_arbiter: RTL

- Shares one single-port word RAM (byte write enables, 1-cycle registered read) between the pipelined CPU's instruction-fetch port and its data port.
- Lets the CPU run from a single-port memory instead of dual_word_ram.
- Sits between pipelined_cpu and the RAM. It issues at most one access per cycle, routes the read data back to whichever requester owned the previous access, and includes a starvation guard so fetch cannot be locked out by back-to-back loads and stores.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_streak_ctr.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the single-port RAM arbiter.
//   owner_e    - which requester owns the access whose read data is
//                arriving this cycle
//   WSTRB_NONE - byte-enable value meaning "no write"
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // Next owner after a grant decision; fetch wins if both flags were set.
    function automatic owner_e next_owner(input logic i_gnt, input logic d_gnt);
        if (i_gnt) begin
            return OWN_I;
        end else if (d_gnt) begin
            return OWN_D;
        end
        return OWN_IDLE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch port, CPU data port and RAM port.
//   slave  - arbiter view: takes requests/mem_rdata, drives grants,
//            responses and the RAM address/data/enables
//   master - environment view (CPU + RAM): the opposite directions
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 14
);

    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wenable;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_wenable,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_wenable,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// arb_streak_ctr: counts consecutive data grants taken while fetch was
// also waiting, saturating at MAX_STREAK.
//   clk, rst       - clock, asynchronous active-high reset
//   i_req_i        - fetch request pending
//   i_gnt_i        - fetch granted this cycle
//   d_gnt_i        - data granted this cycle
//   force_instr_o  - streak has hit MAX_STREAK; fetch must win next contest
module arb_streak_ctr #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned STREAK_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_gnt_i,
    input  logic d_gnt_i,
    output logic force_instr_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        // Only data grants that actually made fetch wait count toward the streak.
        if (i_gnt_i || !i_req_i) begin
            streak_d = '0;
        end else if (d_gnt_i && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_instr_o = (streak_q == STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word RAM (byte enables,
// 1-cycle registered read) between a CPU fetch port and data port.
// At most one access is granted per cycle; the read data returning the
// next cycle is steered to whichever port owned that access.
//   clk  - system clock
//   rst  - asynchronous active-high reset; also gates grants, rvalids
//          and RAM write enables combinationally while high
//   bus  - fetch port, data port and RAM port (slave modport)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned STREAK_W   = 3
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    owner_e owner_q;
    owner_e owner_d;

    logic   i_gnt;
    logic   d_gnt;
    logic   force_instr;

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK),
        .STREAK_W   (STREAK_W)
    ) u_streak (
        .clk           (clk),
        .rst           (rst),
        .i_req_i       (bus.i_req),
        .i_gnt_i       (i_gnt),
        .d_gnt_i       (d_gnt),
        .force_instr_o (force_instr)
    );

    // Grant decision and owner next state.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (!rst) begin
            // Data normally wins a contest unless the starvation guard fires.
            if (bus.d_req && !(bus.i_req && force_instr)) begin
                d_gnt = 1'b1;
            end else if (bus.i_req) begin
                i_gnt = 1'b1;
            end
        end
        owner_d = next_owner(i_gnt, d_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign bus.i_gnt       = i_gnt;
    assign bus.d_gnt       = d_gnt;

    assign bus.mem_addr    = i_gnt ? bus.i_addr[ADDR_W-1:0] : bus.d_addr[ADDR_W-1:0];
    assign bus.mem_wdata   = bus.d_wdata;
    assign bus.mem_wenable = d_gnt ? bus.d_wstrb : WSTRB_NONE;

    // Responses come straight from the owner register so a new grant can
    // overlap the previous access's rvalid.
    assign bus.i_rvalid    = !rst && (owner_q == OWN_I);
    assign bus.d_rvalid    = !rst && (owner_q == OWN_D);
    assign bus.i_rdata     = bus.mem_rdata;
    assign bus.d_rdata     = bus.mem_rdata;

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{bus.i_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};
        end
    endgenerate

endmodule
